// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave in front of a register-array memory, with burst auto-increment,
// frame-abort detection, MISO output enable and debug status.
module spi_memory_burst #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic       busy,
  output logic       word_done,
  output logic       frame_abort,
  output logic [3:0] leds
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int SW    = (ADDR_WIDTH > DATA_WIDTH - 1) ? ADDR_WIDTH : DATA_WIDTH - 1;
  localparam int MAXB  = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW    = $clog2(MAXB + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    WRITE  = 2'd2,
    READ   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s, rise, fall, cs_fall;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [SW-1:0]          shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  tx_q, tx_d;
  logic                   tx_load_q, tx_load_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, busy_q;
  logic                   word_done_q, word_done_d;
  logic                   abort_q, abort_d;
  logic                   last_read_q, last_read_d;
  logic                   sticky_q, sticky_d;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_prev_q;
  assign fall    = ~sclk_s & sclk_prev_q;
  assign cs_fall = cs_prev_q & ~cs_s;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    tx_load_d   = 1'b0;
    miso_d      = miso_q;
    word_done_d = 1'b0;
    abort_d     = 1'b0;
    last_read_d = last_read_q;
    sticky_d    = sticky_q;
    mem_we      = 1'b0;
    mem_wdata   = {shift_q[DATA_WIDTH-2:0], mosi_s};

    if (tx_load_q) tx_d = mem_q[addr_q];

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d   = HEADER;
          bit_cnt_d = '0;
        end
      end
      HEADER: begin
        if (rise) begin
          shift_d = {shift_q[SW-2:0], mosi_s};
          if (bit_cnt_q == CW'(ADDR_WIDTH)) begin
            addr_d      = shift_q[ADDR_WIDTH-1:0];
            last_read_d = mosi_s;
            bit_cnt_d   = '0;
            state_d     = mosi_s ? READ : WRITE;
            tx_load_d   = mosi_s;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      WRITE: begin
        if (rise) begin
          shift_d = {shift_q[SW-2:0], mosi_s};
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            mem_we      = 1'b1;
            word_done_d = 1'b1;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            bit_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      READ: begin
        if (fall) begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = tx_q << 1;
        end
        if (rise) begin
          if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
            word_done_d = 1'b1;
            addr_d      = addr_q + ADDR_WIDTH'(1);
            bit_cnt_d   = '0;
            tx_load_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A final bit landing with cs rise has already cleared the count, so it commits without abort.
    if (state_q != IDLE && cs_s) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      tx_load_d = 1'b0;
      abort_d   = (bit_cnt_d != '0);
      sticky_d  = sticky_q | abort_d;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      tx_load_q   <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
      abort_q     <= 1'b0;
      last_read_q <= 1'b0;
      sticky_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      tx_load_q   <= tx_load_d;
      miso_q      <= miso_d;
      miso_oe_q   <= (state_d == READ);
      busy_q      <= (state_d != IDLE);
      word_done_q <= word_done_d;
      abort_q     <= abort_d;
      last_read_q <= last_read_d;
      sticky_q    <= sticky_d;
      if (mem_we) mem_q[addr_q] <= mem_wdata;
    end
  end

  assign miso_pin    = miso_q;
  assign miso_oe     = miso_oe_q;
  assign busy        = busy_q;
  assign word_done   = word_done_q;
  assign frame_abort = abort_q;
  assign leds        = {state_q, last_read_q, sticky_q};

endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: two instances (7x8 and 4x16) share SCLK/MOSI, each has its own CS.
module tb_spi_memory_burst;
  logic clk = 1'b0, reset = 1'b1, sclk = 1'b0, mosi = 1'b0, cs0 = 1'b1, cs1 = 1'b1;
  logic miso0, oe0, busy0, wd0, ab0;
  logic miso1, oe1, busy1, wd1, ab1;
  logic [3:0] leds0, leds1;

  always #5 clk = ~clk;

  spi_memory_burst #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs0), .mosi_pin(mosi),
    .miso_pin(miso0), .miso_oe(oe0), .busy(busy0), .word_done(wd0),
    .frame_abort(ab0), .leds(leds0));

  spi_memory_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs1), .mosi_pin(mosi),
    .miso_pin(miso1), .miso_oe(oe1), .busy(busy1), .word_done(wd1),
    .frame_abort(ab1), .leds(leds1));

  localparam int H = 8;
  int errors = 0, checks = 0, sel = 0;
  int wd_cnt0 = 0, wd_cnt1 = 0, ab_cnt0 = 0, ab_cnt1 = 0;
  logic [7:0]  m8  [128];
  logic [15:0] m16 [16];
  logic [15:0] wq[$];

  always @(posedge clk) begin
    if (wd0) wd_cnt0++;
    if (wd1) wd_cnt1++;
    if (ab0) ab_cnt0++;
    if (ab1) ab_cnt1++;
  end

  function automatic int aw(); return sel ? 4 : 7; endfunction
  function automatic int dw(); return sel ? 16 : 8; endfunction
  function automatic int wdc(); return sel ? wd_cnt1 : wd_cnt0; endfunction
  function automatic int abc(); return sel ? ab_cnt1 : ab_cnt0; endfunction
  function automatic logic cur_busy(); return sel ? busy1 : busy0; endfunction
  function automatic logic cur_oe(); return sel ? oe1 : oe0; endfunction

  task automatic model_clear();
    for (int i = 0; i < 128; i++) m8[i] = '0;
    for (int i = 0; i < 16; i++) m16[i] = '0;
  endtask

  task automatic model_write(input int a, input logic [15:0] d);
    if (sel != 0) m16[a % 16] = d;
    else m8[a % 128] = d[7:0];
  endtask

  function automatic logic [15:0] model_read(input int a);
    return (sel != 0) ? m16[a % 16] : {8'h00, m8[a % 128]};
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bit(input logic b, output logic m, output logic oe);
    mosi = b;
    wait_clk(H);
    m  = sel ? miso1 : miso0;
    oe = sel ? oe1 : oe0;
    sclk = 1'b1;
    wait_clk(H);
    sclk = 1'b0;
  endtask

  task automatic frame_start();
    if (sel != 0) cs1 = 1'b0;
    else cs0 = 1'b0;
    wait_clk(H);
  endtask

  task automatic frame_end();
    wait_clk(H);
    cs0 = 1'b1;
    cs1 = 1'b1;
    wait_clk(3 * H);
  endtask

  task automatic send_header(input int addr, input logic rw);
    logic m, oe;
    for (int i = aw() - 1; i >= 0; i--) spi_bit(addr[i], m, oe);
    spi_bit(rw, m, oe);
  endtask

  task automatic xfer_word(input logic [15:0] w, output logic [15:0] r, output logic oe_all);
    logic m, oe;
    r = '0;
    oe_all = 1'b1;
    for (int i = dw() - 1; i >= 0; i--) begin
      spi_bit(w[i], m, oe);
      r[i] = m;
      oe_all &= oe;
    end
  endtask

  task automatic run_burst(input string nm, input int addr, input logic rw, input int n);
    int wd_s, ab_s, a;
    logic [15:0] r, w, exp;
    logic oe_all;
    wd_s = wdc();
    ab_s = abc();
    frame_start();
    checks++;
    if (cur_busy() !== 1'b1) begin
      errors++; $display("FAIL %s busy_in_frame: got %b want 1", nm, cur_busy());
    end
    send_header(addr, rw);
    for (int k = 0; k < n; k++) begin
      a = (addr + k) % (2 ** aw());
      if (rw) begin
        exp = model_read(a);
        xfer_word(16'h0000, r, oe_all);
        checks++;
        if (r !== exp) begin
          errors++; $display("FAIL %s rdata[%0d] @%0h: got %h want %h", nm, k, a, r, exp);
        end
        checks++;
        if (oe_all !== 1'b1) begin
          errors++; $display("FAIL %s miso_oe[%0d]: got %b want 1", nm, k, oe_all);
        end
      end else begin
        w = (wq.size() > 0) ? wq.pop_front() : 16'(int'($urandom));
        xfer_word(w, r, oe_all);
        model_write(a, w);
      end
    end
    frame_end();
    checks++;
    if (wdc() - wd_s !== n) begin
      errors++; $display("FAIL %s word_done_count: got %0d want %0d", nm, wdc() - wd_s, n);
    end
    checks++;
    if (abc() - ab_s !== 0) begin
      errors++; $display("FAIL %s no_abort: got %0d want 0", nm, abc() - ab_s);
    end
    checks++;
    if ({cur_busy(), cur_oe()} !== 2'b00) begin
      errors++; $display("FAIL %s idle_after: busy,oe got %b want 00", nm, {cur_busy(), cur_oe()});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_clk(5);
    reset = 1'b0;
    model_clear();
    wait_clk(4);
    checks++;
    if ({miso0, oe0, busy0, wd0, ab0, leds0} !== 9'd0) begin
      errors++; $display("FAIL reset_dut0: got %b want 0", {miso0, oe0, busy0, wd0, ab0, leds0});
    end
    checks++;
    if ({miso1, oe1, busy1, wd1, ab1, leds1} !== 9'd0) begin
      errors++; $display("FAIL reset_dut1: got %b want 0", {miso1, oe1, busy1, wd1, ab1, leds1});
    end
  endtask

  task automatic test_read_cleared();
    sel = 0;
    run_burst("rd_cleared", 'h05, 1'b1, 1);
  endtask

  task automatic test_write_read();
    sel = 0;
    wq.push_back(16'h00A5);
    run_burst("wr_2a", 'h2A, 1'b0, 1);
    run_burst("rd_2a", 'h2A, 1'b1, 1);
  endtask

  task automatic test_burst_wrap();
    sel = 0;
    wq.push_back(16'h0011);
    wq.push_back(16'h0022);
    run_burst("wr_wrap", 'h7F, 1'b0, 2);
    run_burst("rd_wrap", 'h7F, 1'b1, 2);
    run_burst("rd_wrap0", 'h00, 1'b1, 1);
  endtask

  task automatic test_abort();
    logic m, oe;
    int ab_s;
    sel = 0;
    ab_s = ab_cnt0;
    frame_start();
    send_header('h10, 1'b0);
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom), m, oe);
    frame_end();
    checks++;
    if (ab_cnt0 - ab_s !== 1) begin
      errors++; $display("FAIL abort_word_pulse: got %0d cycles want 1", ab_cnt0 - ab_s);
    end
    checks++;
    if ({leds0[0], oe0, busy0} !== 3'b100) begin
      errors++; $display("FAIL abort_status: sticky,oe,busy got %b want 100", {leds0[0], oe0, busy0});
    end
    run_burst("rd_after_abort", 'h10, 1'b1, 1);
    ab_s = ab_cnt0;
    frame_start();
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m, oe);
    frame_end();
    checks++;
    if (ab_cnt0 - ab_s !== 1) begin
      errors++; $display("FAIL abort_header_pulse: got %0d cycles want 1", ab_cnt0 - ab_s);
    end
  endtask

  task automatic test_wide();
    sel = 1;
    wq.push_back(16'hBEEF);
    run_burst("wide_wr", 'h3, 1'b0, 1);
    run_burst("wide_rd", 'h3, 1'b1, 1);
    wq.push_back(16'h1234);
    wq.push_back(16'hABCD);
    run_burst("wide_wr_wrap", 'hF, 1'b0, 2);
    run_burst("wide_rd_wrap", 'hF, 1'b1, 2);
    run_burst("wide_rd0", 'h0, 1'b1, 1);
  endtask

  task automatic test_random();
    int a, n;
    for (int it = 0; it < 6; it++) begin
      sel = int'($urandom_range(0, 1));
      a = int'($urandom_range(0, 2 ** aw() - 1));
      n = int'($urandom_range(1, 3));
      run_burst("rnd_wr", a, 1'b0, n);
      run_burst("rnd_rd", a, 1'b1, n);
    end
  endtask

  task automatic test_reset_mid();
    logic m, oe;
    sel = 0;
    wq.push_back(16'h005A);
    run_burst("wr_pre_reset", 'h20, 1'b0, 1);
    frame_start();
    send_header('h20, 1'b1);
    spi_bit(1'b0, m, oe);
    spi_bit(1'b0, m, oe);
    mosi = 1'b0;
    wait_clk(H);
    sclk = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({oe0, busy0, leds0} !== 6'd0) begin
      errors++; $display("FAIL reset_mid: oe,busy,leds got %b want 0", {oe0, busy0, leds0});
    end
    cs0 = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    model_clear();
    wait_clk(H);
    wq.push_back(16'h003C);
    run_burst("wr_post_reset", 'h01, 1'b0, 1);
    run_burst("rd_post_reset", 'h01, 1'b1, 1);
    run_burst("rd_cleared_20", 'h20, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_read_cleared();
    test_write_read();
    test_burst_wrap();
    test_abort();
    test_wide();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
